// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and byte-merge helper for the multi-port register file
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Widest register the merge helper handles; callers size-cast in and out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BYTES-1:0]  strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - sequential bulk-clear engine, one entry per cycle
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              idle_o,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter wraps to 0 on the cycle that clears the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (clr_req_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    idle_o     = (state_q == ST_IDLE);
    clr_busy_o = (state_q == ST_CLEAR) || (state_q == ST_DONE);
    clr_done_o = (state_q == ST_DONE);
    clr_en_o   = (state_q == ST_CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with strobed writes, bypass and bulk clear
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic [NREAD-1:0]        re,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = bytes_of(DATA_W);

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BYTES-1:0]  strb
  );
    return DATA_W'(merge_bytes(MAX_DATA_W'(old_v), MAX_DATA_W'(new_v), MAX_BYTES'(strb)));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_drop_q, wr_drop_d;

  logic              idle;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_val;
  logic              waddr_zero;

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (clr_req),
    .idle_o     (idle),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  assign waddr_zero = (ZERO_REG != 0) && (waddr == '0);

  // Clearing owns the single write port; architectural writes only land in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_val  = merge_w(mem_q[waddr], wdata, wstrb);
    if (clr_en) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_val  = '0;
    end else if (idle && we && (wstrb != '0) && !waddr_zero) begin
      wr_en = 1'b1;
    end
  end

  assign wr_drop_d = we && clr_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
      if (wr_en) mem_q[wr_addr] <= wr_val;
    end
  end

  assign wr_drop = wr_drop_q;

  // Bypass forwards the same merged value the write edge will store.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (re[p] && !((ZERO_REG != 0) && (ra == '0))) begin
        if (idle && we && (ra == waddr)) rd = merge_w(mem_q[ra], wdata, wstrb);
        else                             rd = mem_q[ra];
      end
    end

    assign rdata[p*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;
  localparam int BUSY  = DEPTH + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           we = 1'b0;
  logic [AW-1:0]  waddr = '0;
  logic [DW-1:0]  wdata = '0;
  logic [3:0]     wstrb = '0;
  logic [NR-1:0]  re = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic           clr_req = 1'b0;
  logic           clr_busy, clr_done, wr_drop;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  // Model: register contents plus remaining busy cycles of a clear in flight.
  logic [DW-1:0] m_mem [DEPTH];
  int            busy_left = 0;
  logic          m_wr_drop = 1'b0;

  function automatic logic [DW-1:0] mmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [3:0] s);
    logic [DW-1:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int p);
    logic [AW-1:0] a;
    a = raddr[p*AW +: AW];
    if (!re[p] || a == 0) return '0;
    if (busy_left == 0 && we && a == waddr) return mmerge(m_mem[a], wdata, wstrb);
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      busy_left = 0;
      m_wr_drop = 1'b0;
    end else begin
      m_wr_drop = (busy_left > 0) && we;
      if (busy_left == 0) begin
        if (we && waddr != 0) m_mem[waddr] = mmerge(m_mem[waddr], wdata, wstrb);
        if (clr_req) busy_left = BUSY;
      end else begin
        if (busy_left > 1) m_mem[BUSY - busy_left] = '0;
        busy_left = busy_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], exp_read(p));
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, busy_left > 0});
    chk("clr_done", {31'd0, clr_done}, {31'd0, busy_left == 1});
    chk("wr_drop", {31'd0, wr_drop}, {31'd0, m_wr_drop});
    if (rst_n && clr_busy) busy_cnt++;
    if (rst_n && clr_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    we = 1'b0;
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    raddr = {a1, a0};
    re = en;
    #1;
  endtask

  task automatic start_clear();
    busy_cnt = 0;
    done_cnt = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!clr_busy) break;
    end
    chk("clear_timeout", {31'd0, clr_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then read
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd2(5'd3, 5'd7, 2'b11);
    chk("rst_rd0", rdata[31:0], 32'h0);
    chk("rst_rd1", rdata[63:32], 32'h0);
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);

    // 2: strobed write and bypass
    wr(5'd5, 32'hAABBCCDD, 4'hF);
    we = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wstrb = 4'b0101;
    rd2(5'd5, 5'd7, 2'b01);
    chk("bypass_pre", rdata[31:0], 32'hAA22CC44);
    tick();
    we = 1'b0;
    #1;
    chk("bypass_post", rdata[31:0], 32'hAA22CC44);
    wr(5'd5, 32'hFFFFFFFF, 4'h0);
    chk("strb0_noop", rdata[31:0], 32'hAA22CC44);

    // 3: zero register and read enable
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    rd2(5'd0, 5'd0, 2'b11);
    chk("zero_rd0", rdata[31:0], 32'h0);
    wr(5'd6, 32'hAABBCCDD, 4'hF);
    rd2(5'd6, 5'd6, 2'b10);
    chk("re0_off", rdata[31:0], 32'h0);
    chk("re1_on", rdata[63:32], 32'hAABBCCDD);

    // 4: bulk clear with mid-clear observation
    wr(5'd1, 32'h01010101, 4'hF);
    wr(5'd17, 32'h17171717, 4'hF);
    wr(5'd31, 32'h31313131, 4'hF);
    start_clear();
    repeat (10) tick();
    rd2(5'd1, 5'd17, 2'b11);
    chk("mid_e1", rdata[31:0], 32'h0);
    chk("mid_e17", rdata[63:32], 32'h17171717);
    wait_end();
    chk("busy_cycles", busy_cnt, BUSY);
    chk("done_pulses", done_cnt, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd2(a[AW-1:0], a[AW-1:0], 2'b11);
      tick();
    end
    rd2(5'd17, 5'd31, 2'b11);
    chk("post_e17", rdata[31:0], 32'h0);
    chk("post_e31", rdata[63:32], 32'h0);

    // 5: write during clear, and write together with clr_req
    start_clear();
    repeat (20) tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h5; wstrb = 4'hF;
    tick();
    we = 1'b0;
    chk("wr_drop_hi", {31'd0, wr_drop}, 32'd1);
    tick();
    chk("wr_drop_lo", {31'd0, wr_drop}, 32'd0);
    wait_end();
    rd2(5'd9, 5'd9, 2'b11);
    chk("drop_e9", rdata[31:0], 32'h0);
    we = 1'b1; waddr = 5'd4; wdata = 32'h1234; wstrb = 4'hF; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    rd2(5'd4, 5'd4, 2'b11);
    chk("wr_clr_e4", rdata[31:0], 32'h1234);
    chk("wr_clr_busy", {31'd0, clr_busy}, 32'd1);
    wait_end();
    rd2(5'd4, 5'd4, 2'b11);
    chk("wr_clr_e4_end", rdata[31:0], 32'h0);

    // 6: asynchronous reset mid-clear
    wr(5'd20, 32'hDEADBEEF, 4'hF);
    start_clear();
    repeat (12) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, clr_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd2(5'd20, 5'd20, 2'b11);
    chk("arst_e20", rdata[31:0], 32'h0);
    chk("arst_no_done", done_cnt, 0);
    start_clear();
    wait_end();
    chk("fresh_busy", busy_cnt, BUSY);
    chk("fresh_done", done_cnt, 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-write, two-read CPU register file.
- Adds configurable width, depth and read-port count, byte-strobed writes and write-to-read bypass.
- Adds a sequential bulk-clear engine (FSM, one entry per cycle) so the datapath can reset architectural state without asserting global reset.
- Sits in the decode stage of the multi-cycle CPU; the control unit drives the write port and the clear handshake.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of independent read ports.
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero: writes ignored, reads return 0.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- we  in  1  Write enable.
- waddr  in  ADDR_W  Write address.
- wdata  in  DATA_W  Write data.
- wstrb  in  DATA_W/8  Byte-lane write mask; bit i enables bits [8i+7:8i].
- re  in  NREAD  Per-port read enable.
- raddr  in  NREAD*ADDR_W  Packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  Packed read data; port p at [p*DATA_W +: DATA_W].
- clr_req  in  1  Bulk-clear request, level-sampled.
- clr_busy  out  1  High while the clear engine runs.
- clr_done  out  1  One-cycle pulse when the clear completes.
- wr_drop  out  1  Registered one-cycle pulse: a write was discarded because the clear engine was busy.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries become 0, FSM goes to IDLE, clear counter becomes 0, and clr_busy, clr_done and wr_drop become 0.
- Reset asserted mid-clear aborts the clear immediately; no clr_done pulse is produced.
- Write:
  - Occurs on the rising edge when we=1 and FSM is IDLE.
  - Only byte lanes with wstrb=1 are updated; wstrb=0 is a no-op.
  - With ZERO_REG=1 and waddr=0, the write is ignored.
- Read (combinational, zero latency):
  - rdata[p] = 0 when re[p]=0.
  - rdata[p] = 0 when ZERO_REG=1 and raddr[p]=0.
  - Otherwise rdata[p] = stored entry.
- Bypass:
  - Applies when FSM is IDLE, we=1 and raddr[p]==waddr (and waddr is not the zero register).
  - rdata[p] = merged value: wdata bytes where wstrb=1, stored bytes elsewhere.
  - The result is therefore identical to reading after the write edge.
  - Every port bypasses independently; several ports may hit the same address.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req=1 at the clock edge; counter is 0.
  - CLEAR: each cycle, entry[counter] <= 0 and counter increments.
  - CLEAR -> DONE after the cycle that clears entry DEPTH-1; counter wraps to 0.
  - DONE -> IDLE unconditionally after one cycle.
  - clr_busy = 1 in CLEAR and DONE.
  - clr_done = 1 in DONE only.
  - A clear takes exactly DEPTH+1 busy cycles: 33 for the defaults.
  - clr_req is ignored outside IDLE. If clr_req is still high in IDLE after DONE, a new clear starts.
- Writes while busy:
  - When clr_busy=1 and we=1, the write is discarded and wr_drop pulses on the next cycle.
  - A write and clr_req in the same IDLE cycle: the write commits at that edge and the clear begins on the following cycle, so the written entry is subsequently cleared.
- Reads while busy:
  - Return current stored contents; entries below the counter read 0.
  - Bypass is disabled.
- Multiple read ports never conflict; there is a single write port, so no write-write conflict exists.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (IDLE/CLEAR/DONE);
  - the BYTES = DATA_W/8 helper;
  - the function merge_bytes(old, new, strb), used by both the write path and the bypass path so they match bit-for-bit.
- One natural sub-module: regfile_clr_fsm (state register, counter, clr_busy/clr_done generation, clear-address/clear-enable outputs).
- The read/bypass mux is a generate loop over NREAD, not a sub-module.

Test Plan:
1. Reset then read:
   - Stimulus: rst_n low 2 cycles; release; re=2'b11, raddr={5'd7,5'd3}.
   - Response: rdata=0 on both ports; clr_busy=0.
2. Strobed write and bypass:
   - Stimulus: write waddr=5, wdata=32'hAABBCCDD, wstrb=4'hF. Next cycle: we=1, waddr=5, wdata=32'h11223344, wstrb=4'b0101, with raddr port0=5 in the same cycle.
   - Response: port0 reads 32'hAA22CC44 combinationally before the edge and after it.
3. Zero register:
   - Stimulus: write waddr=0, wdata=32'hFFFFFFFF, wstrb=4'hF; read raddr=0 with re=1.
   - Response: rdata=0. re=0 on a port holding 32'hAABBCCDD gives 0.
4. Bulk clear:
   - Stimulus: preload entries 1, 17, 31 with nonzero values; pulse clr_req 1 cycle.
   - Response: clr_busy high 33 cycles; clr_done pulses exactly once, in the final busy cycle; all reads return 0 afterwards.
   - Check mid-clear at counter=10: entry 1 reads 0 while entry 17 still holds its value.
5. Write during clear:
   - Stimulus: we=1, waddr=9, wdata=32'h5 while clr_busy=1.
   - Response: wr_drop pulses 1 cycle later; entry 9 reads 0 after clr_done.
   - Also: write and clr_req asserted together in IDLE; the entry ends at 0 after the clear.
6. Reset mid-clear:
   - Stimulus: assert rst_n=0 asynchronously at counter=12 (between edges).
   - Response: clr_busy=0 immediately; no clr_done pulse; all entries 0; next clr_req starts a fresh 33-cycle clear.
